// File: rtl/mux4_bus_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 mux, with a one-entry valid/ready output stage.
// Define MUX4_ARB_FIXED_PRIORITY_EN to switch arbitration to fixed priority (d1 highest).
module mux4_bus_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  input  logic [DATA_W-1:0] d4,
  input  logic              ready,
  output logic [1:0]        select,
  output logic [3:0]        gnt,
  output logic [3:0]        ack,
  output logic [DATA_W-1:0] q,
  output logic              valid
);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  state_t            state, state_next;
  logic [1:0]        last;
  logic [3:0]        beats;
  logic [1:0]        winner;
  logic [DATA_W-1:0] word;
  logic              slot_free;
  logic              do_arb, do_load, do_release;

  function automatic logic [1:0] pick_rr(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    logic       found;
    pick_rr = base;
    found   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = base + 2'(i);
      if (!found && r[idx]) begin
        pick_rr = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [1:0] pick_fixed(input logic [3:0] r);
    pick_fixed = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r[i]) pick_fixed = 2'(i);
    end
  endfunction

`ifdef MUX4_ARB_FIXED_PRIORITY_EN
  assign winner = pick_fixed(req);
`else
  assign winner = pick_rr(req, last);
`endif

  always_comb begin
    case (select)
      2'd0:    word = d1;
      2'd1:    word = d2;
      2'd2:    word = d3;
      default: word = d4;
    endcase
  end

  assign slot_free = !valid || ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|req) state_next = GRANT;
      GRANT:   if (do_release) state_next = DRAIN;
      DRAIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes: the granted source is always the one currently on select.
  always_comb begin
    do_arb     = (state == IDLE) && (|req);
    do_load    = (state == GRANT) && slot_free && req[select] && (beats < HOLD_LIMIT);
    do_release = (state == GRANT) && slot_free && (!req[select] || (beats >= HOLD_LIMIT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      select <= 2'd0;
      gnt    <= 4'd0;
      ack    <= 4'd0;
      q      <= '0;
      valid  <= 1'b0;
      beats  <= 4'd0;
      last   <= 2'd3;
    end else begin
      ack <= 4'd0;
      if (do_arb) begin
        select <= winner;
        gnt    <= 4'b0001 << winner;
        beats  <= 4'd0;
      end
      if (do_load) begin
        q     <= word;
        valid <= 1'b1;
        beats <= beats + 4'd1;
        ack   <= gnt;
      end
      // Release also retires the last word, since the slot was free this edge.
      if (do_release) begin
        gnt   <= 4'd0;
        valid <= 1'b0;
        last  <= select;
      end
    end
  end

endmodule

// File: tb/tb_mux4_bus_arbiter.sv
// Directed bench for mux4_bus_arbiter (default round-robin build).
module tb_mux4_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] d1, d2, d3, d4;
  logic        ready;
  logic [1:0]  select;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [15:0] q;
  logic        valid;

  int n_cmp = 0;
  int n_bad = 0;

  mux4_bus_arbiter #(.MAX_HOLD(4), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .req(req),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4),
    .ready(ready), .select(select), .gnt(gnt), .ack(ack),
    .q(q), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  function automatic int idx_of(input logic [3:0] oh);
    case (oh)
      4'b0001: idx_of = 0;
      4'b0010: idx_of = 1;
      4'b0100: idx_of = 2;
      4'b1000: idx_of = 3;
      default: idx_of = -1;
    endcase
  endfunction

  function automatic logic [15:0] src(input int i);
    case (i)
      0:       src = d1;
      1:       src = d2;
      2:       src = d3;
      default: src = d4;
    endcase
  endfunction

  initial begin
    int acks;
    int xfer;
    int g;
    int order [5];
    int acks_per [5];
    logic [3:0] prev;

    reset = 1'b1; req = 4'd0; ready = 1'b1;
    d1 = 16'hA5A5; d2 = 16'h2222; d3 = 16'h3333; d4 = 16'h4444;
    #2;
    check("rst_valid",  32'(valid),  32'h0);
    check("rst_gnt",    32'(gnt),    32'h0);
    check("rst_select", 32'(select), 32'h0);
    check("rst_q",      32'(q),      32'h0);
    check("rst_ack",    32'(ack),    32'h0);
    step();
    reset = 1'b0;

    // Single requester d1, MAX_HOLD=4
    req = 4'b0001;
    step();
    check("t1_gnt",    32'(gnt),    32'h1);
    check("t1_select", 32'(select), 32'h0);
    check("t1_valid0", 32'(valid),  32'h0);
    step();
    check("t1_q",     32'(q),     32'hA5A5);
    check("t1_valid", 32'(valid), 32'h1);
    check("t1_ack",   32'(ack),   32'h1);
    acks = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ack[0]) acks++;
    end
    req = 4'd0;
    check("t1_acks",    acks,        4);
    check("t1_release", 32'(gnt),    32'h0);
    check("t1_valid_e", 32'(valid),  32'h0);

    // All four requesting: rotation d1,d2,d3,d4,d1
    do_reset();
    d1 = 16'h1111;
    req = 4'b1111;
    g = 0; prev = 4'd0;
    for (int k = 0; k < 5; k++) begin order[k] = -1; acks_per[k] = 0; end
    for (int c = 0; c < 30; c++) begin
      step();
      if (gnt != 4'd0 && prev == 4'd0 && g < 5) begin
        order[g] = idx_of(gnt);
        g++;
      end
      if (ack != 4'd0 && g > 0) begin
        check("rr_ack_gnt", 32'(ack), 32'(gnt));
        check("rr_q",       32'(q),   32'(src(order[g-1])));
        acks_per[g-1]++;
      end
      prev = gnt;
    end
    check("rr_grants", g, 5);
    for (int k = 0; k < 5; k++) check("rr_order", order[k], k % 4);
    for (int k = 0; k < 4; k++) check("rr_beats", acks_per[k], 4);
    req = 4'd0;

    // d2 streaming with a 3-cycle ready stall
    do_reset();
    d2 = 16'hBEEF;
    req = 4'b0010;
    step();
    check("st_gnt",    32'(gnt),    32'h2);
    check("st_select", 32'(select), 32'h1);
    acks = 0; xfer = 0;
    step();
    if (ack[1]) acks++;
    check("st_valid", 32'(valid), 32'h1);
    check("st_q",     32'(q),     32'hBEEF);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", 32'(valid), 32'h1);
      check("stall_ack",   32'(ack),   32'h0);
      check("stall_q",     32'(q),     32'hBEEF);
      check("stall_gnt",   32'(gnt),   32'h2);
    end
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (valid && ready) xfer++;
      step();
      if (ack[1]) acks++;
      if (gnt == 4'd0) break;
    end
    check("st_release", 32'(gnt), 32'h0);
    check("st_acks",    acks, 4);
    check("st_xfers",   xfer, 4);
    req = 4'd0;

    // d3 drops its request after 2 beats while d1 waits
    do_reset();
    d3 = 16'h3C3C;
    req = 4'b0100;
    step();
    check("dr_gnt",    32'(gnt),    32'h4);
    check("dr_select", 32'(select), 32'h2);
    req = 4'b0101;
    acks = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (ack[2]) acks++;
    end
    check("dr_acks", acks, 2);
    check("dr_q",    32'(q), 32'h3C3C);
    req = 4'b0001;
    step();
    check("dr_release", 32'(gnt),   32'h0);
    check("dr_valid",   32'(valid), 32'h0);
    step();
    check("dr_dead",    32'(gnt),   32'h0);
    step();
    check("dr_next_gnt", 32'(gnt),    32'h1);
    check("dr_next_sel", 32'(select), 32'h0);

    // Asynchronous reset while a word is held
    step();
    check("ar_valid_pre", 32'(valid), 32'h1);
    check("ar_q_pre",     32'(q),     32'h1111);
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid",  32'(valid),  32'h0);
    check("ar_gnt",    32'(gnt),    32'h0);
    check("ar_q",      32'(q),      32'h0);
    check("ar_select", 32'(select), 32'h0);
    check("ar_ack",    32'(ack),    32'h0);
    req = 4'b0110;
    step();
    reset = 1'b0;
    step();
    check("ar_gnt_d2", 32'(gnt),    32'h2);
    check("ar_sel_d2", 32'(select), 32'h1);
    step();
    check("ar_q_d2",   32'(q),      32'hBEEF);
    req = 4'd0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
